// File: rtl/fb_pkg.sv
// Shared constants, state encoding and slot-merge helper for the coarse
// 80x60 framebuffer (two 3-bit pixels packed per 6-bit RAM word).
package fb_pkg;

    localparam int RESOLUTION_H  = 1280;
    localparam int RESOLUTION_V  = 960;
    localparam int SCALE_SHIFT   = 4;
    localparam int FB_W          = 80;
    localparam int FB_H          = 60;
    localparam int RAM_DATAWIDTH = 6;
    localparam int RAMLENGTH     = FB_W * FB_H / 2;
    localparam int X_WIRE_WIDTH  = 11;
    localparam int Y_WIRE_WIDTH  = 10;
    localparam int ADDR_WIDTH    = $clog2(RAMLENGTH);

    // Derived widths for the coordinate-to-cell mapping.
    localparam int COL_W         = X_WIRE_WIDTH - SCALE_SHIFT;
    localparam int ROW_W         = Y_WIRE_WIDTH - SCALE_SHIFT;
    localparam int IDX_W         = $clog2(FB_W * FB_H);

    // Pixel slot layout inside one RAM word.
    localparam int PIX_W         = 3;
    localparam int SLOT0_LSB     = 0;
    localparam int SLOT0_MSB     = SLOT0_LSB + PIX_W - 1;
    localparam int SLOT1_LSB     = PIX_W;
    localparam int SLOT1_MSB     = SLOT1_LSB + PIX_W - 1;

    localparam int PIX_CNT_W     = 16;
    localparam int DROP_CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WT   = 2'd2,
        WR   = 2'd3
    } state_e;

    // Replace one slot of a packed word, leaving the other slot bit-exact.
    function automatic logic [RAM_DATAWIDTH-1:0] merge_slot(
        input logic [RAM_DATAWIDTH-1:0] word,
        input logic                     slot,
        input logic [PIX_W-1:0]         rgb
    );
        logic [RAM_DATAWIDTH-1:0] res;
        res = word;
        if (slot) begin
            res[SLOT1_MSB:SLOT1_LSB] = rgb;
        end else begin
            res[SLOT0_MSB:SLOT0_LSB] = rgb;
        end
        return res;
    endfunction

endpackage

// File: rtl/fb_pixel_writer_if.sv
// Command-FIFO read side and framebuffer RAM port of the pixel writer.
interface fb_pixel_writer_if;

    logic                               fifo_empty;
    logic [fb_pkg::X_WIRE_WIDTH-1:0]    fifo_hpos;
    logic [fb_pkg::Y_WIRE_WIDTH-1:0]    fifo_vpos;
    logic [fb_pkg::PIX_W-1:0]           fifo_rgb;
    logic                               fifo_rd;
    logic [fb_pkg::ADDR_WIDTH-1:0]      ram_addr;
    logic [fb_pkg::RAM_DATAWIDTH-1:0]   ram_rdata;
    logic [fb_pkg::RAM_DATAWIDTH-1:0]   ram_wdata;
    logic                               ram_we;

    // Writer side: pops commands and drives the RAM port.
    modport master (
        input  fifo_empty, fifo_hpos, fifo_vpos, fifo_rgb, ram_rdata,
        output fifo_rd, ram_addr, ram_wdata, ram_we
    );

    // Environment side: FIFO and RAM.
    modport slave (
        output fifo_empty, fifo_hpos, fifo_vpos, fifo_rgb, ram_rdata,
        input  fifo_rd, ram_addr, ram_wdata, ram_we
    );

endinterface

// File: rtl/fb_addr_map.sv
// Screen coordinate to framebuffer word/slot mapping, with range check.
module fb_addr_map
    import fb_pkg::*;
(
    input  logic [X_WIRE_WIDTH-1:0] hpos,
    input  logic [Y_WIRE_WIDTH-1:0] vpos,
    output logic [ADDR_WIDTH-1:0]   word,
    output logic                    slot,
    output logic                    out_of_range
);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [IDX_W-1:0] idx;

    // Downscale to a cell, linearise, then split into word and slot.
    always_comb begin
        col          = hpos[X_WIRE_WIDTH-1:SCALE_SHIFT];
        row          = vpos[Y_WIRE_WIDTH-1:SCALE_SHIFT];
        idx          = IDX_W'(row) * IDX_W'(FB_W) + IDX_W'(col);
        word         = idx[IDX_W-1:1];
        slot         = idx[0];
        out_of_range = (hpos >= X_WIRE_WIDTH'(RESOLUTION_H)) ||
                       (vpos >= Y_WIRE_WIDTH'(RESOLUTION_V));
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Pops pixel commands and read-modify-writes the packed framebuffer RAM,
// using the RAM port only while scan-out is blanked.
module fb_pixel_writer
    import fb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  display_on,
    fb_pixel_writer_if.master     bus,
    output logic                  busy,
    output logic [PIX_CNT_W-1:0]  pix_cnt,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    state_e                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    word_q, word_d;
    logic                     slot_q, slot_d;
    logic [PIX_W-1:0]         rgb_q, rgb_d;
    logic [RAM_DATAWIDTH-1:0] wdata_q, wdata_d;
    logic [PIX_CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic [DROP_CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                     pop;

    logic [ADDR_WIDTH-1:0]    map_word;
    logic                     map_slot;
    logic                     map_oor;

    fb_addr_map u_addr_map (
        .hpos         (bus.fifo_hpos),
        .vpos         (bus.fifo_vpos),
        .word         (map_word),
        .slot         (map_slot),
        .out_of_range (map_oor)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= '0;
            slot_q     <= 1'b0;
            rgb_q      <= '0;
            wdata_q    <= '0;
            pix_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            slot_q     <= slot_d;
            rgb_q      <= rgb_d;
            wdata_q    <= wdata_d;
            pix_cnt_q  <= pix_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Next-state, command latch, merge and counters.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        slot_d     = slot_q;
        rgb_d      = rgb_q;
        wdata_d    = wdata_q;
        pix_cnt_d  = pix_cnt_q;
        drop_cnt_d = drop_cnt_q;
        pop        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!bus.fifo_empty && !display_on) begin
                    pop = 1'b1;
                    if (map_oor) begin
                        if (drop_cnt_q != '1) begin
                            drop_cnt_d = drop_cnt_q + 1'b1;
                        end
                    end else begin
                        word_d  = map_word;
                        slot_d  = map_slot;
                        rgb_d   = bus.fifo_rgb;
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (!display_on) begin
                    state_d = WT;
                end
            end
            WT: begin
                if (display_on) begin
                    state_d = RD;
                end else begin
                    wdata_d = merge_slot(bus.ram_rdata, slot_q, rgb_q);
                    state_d = WR;
                end
            end
            WR: begin
                if (!display_on) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. The write strobe is additionally gated by display_on so
    // scan-out never sees a write in a cycle it owns the port.
    always_comb begin
        bus.fifo_rd   = pop;
        bus.ram_addr  = word_q;
        bus.ram_wdata = wdata_q;
        bus.ram_we    = (state_q == WR) && !display_on;
        busy          = (state_q != IDLE);
        pix_cnt       = pix_cnt_q;
        drop_cnt      = drop_cnt_q;
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed, table-driven bench for fb_pixel_writer with a behavioural RAM.
module tb_fb_pixel_writer;

    logic        clk;
    logic        rst_n;
    logic        display_on;
    logic        busy;
    logic [15:0] pix_cnt;
    logic [7:0]  drop_cnt;

    fb_pixel_writer_if bus ();

    fb_pixel_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .display_on (display_on),
        .bus        (bus),
        .busy       (busy),
        .pix_cnt    (pix_cnt),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: 1-cycle read latency, bench preload port.
    logic [5:0]  mem [0:2399];
    logic        clr;
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [5:0]  pl_val;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 2400; i++) mem[i] <= '0;
        end else begin
            if (pl_en) mem[pl_addr] <= pl_val;
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    int n_cmp;
    int n_fail;
    int bad_we;
    int bad_rd;

    // Protocol invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ram_we && display_on) bad_we++;
            if (bus.fifo_rd && (bus.fifo_empty || display_on || busy)) bad_rd++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [10:0] h;
        logic [9:0]  v;
        logic [2:0]  rgb;
        logic [5:0]  pre;
        logic        oor;
        logic [11:0] addr;
        logic [5:0]  wdata;
    } vec_t;

    vec_t vecs[12];
    int   exp_pix;
    int   exp_drop;

    task automatic preload(input logic [11:0] a, input logic [5:0] d);
        pl_addr = a;
        pl_val  = d;
        pl_en   = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Present one command right after a posedge, pop it, release the FIFO.
    task automatic push_cmd(input logic [10:0] h, input logic [9:0] v, input logic [2:0] rgb);
        bus.fifo_hpos  = h;
        bus.fifo_vpos  = v;
        bus.fifo_rgb   = rgb;
        bus.fifo_empty = 1'b0;
        @(negedge clk);
        chk("pop_strobe", bus.fifo_rd, 1);
        @(posedge clk);
        #1 bus.fifo_empty = 1'b1;
    endtask

    task automatic run_vec(input vec_t t);
        if (!t.oor) preload(t.addr, t.pre);
        else begin
            @(posedge clk);
            #1;
        end
        push_cmd(t.h, t.v, t.rgb);
        if (t.oor) begin
            exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
            @(negedge clk);
            chk("drop_busy", busy, 0);
            chk("drop_no_we", bus.ram_we, 0);
            chk("drop_cnt", drop_cnt, exp_drop);
        end else begin
            @(negedge clk);
            chk("rd_busy", busy, 1);
            chk("rd_addr", bus.ram_addr, t.addr);
            chk("rd_no_we", bus.ram_we, 0);
            @(negedge clk);
            chk("wt_no_we", bus.ram_we, 0);
            @(negedge clk);
            chk("wr_we", bus.ram_we, 1);
            chk("wr_addr", bus.ram_addr, t.addr);
            chk("wr_wdata", bus.ram_wdata, t.wdata);
            exp_pix++;
            @(negedge clk);
            chk("done_idle", busy, 0);
            chk("pix_cnt", pix_cnt, exp_pix);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        int rd_pulses;
        int lat;

        n_cmp = 0; n_fail = 0; bad_we = 0; bad_rd = 0;
        exp_pix = 0; exp_drop = 0;

        //          h      v     rgb  pre    oor  addr   wdata
        vecs[0]  = '{11'd0,    10'd0,   3'd5, 6'h00, 1'b0, 12'd0,    6'h05};
        vecs[1]  = '{11'd16,   10'd0,   3'd3, 6'h05, 1'b0, 12'd0,    6'h1D};
        vecs[2]  = '{11'd1279, 10'd959, 3'd7, 6'h00, 1'b0, 12'd2399, 6'h38};
        vecs[3]  = '{11'd1280, 10'd0,   3'd1, 6'h00, 1'b1, 12'd0,    6'h00};
        vecs[4]  = '{11'd15,   10'd15,  3'd2, 6'h3F, 1'b0, 12'd0,    6'h3A};
        vecs[5]  = '{11'd32,   10'd16,  3'd4, 6'h2A, 1'b0, 12'd41,   6'h2C};
        vecs[6]  = '{11'd48,   10'd16,  3'd6, 6'h07, 1'b0, 12'd41,   6'h37};
        vecs[7]  = '{11'd0,    10'd960, 3'd3, 6'h00, 1'b1, 12'd0,    6'h00};
        vecs[8]  = '{11'd640,  10'd480, 3'd1, 6'h38, 1'b0, 12'd1220, 6'h39};
        vecs[9]  = '{11'd1264, 10'd0,   3'd0, 6'h3F, 1'b0, 12'd39,   6'h07};
        vecs[10] = '{11'd2047, 10'd1023,3'd7, 6'h00, 1'b1, 12'd0,    6'h00};
        vecs[11] = '{11'd1279, 10'd944, 3'd5, 6'h07, 1'b0, 12'd2399, 6'h2F};

        rst_n = 1'b0; display_on = 1'b0; clr = 1'b1; pl_en = 1'b0;
        pl_addr = '0; pl_val = '0;
        bus.fifo_empty = 1'b1; bus.fifo_hpos = '0; bus.fifo_vpos = '0; bus.fifo_rgb = '0;

        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("rst_fifo_rd", bus.fifo_rd, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_wdata", bus.ram_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pix_cnt", pix_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Back-to-back drops pop every cycle and saturate the drop counter.
        @(posedge clk);
        #1;
        bus.fifo_hpos = 11'd1280; bus.fifo_vpos = 10'd0; bus.fifo_rgb = 3'd1;
        bus.fifo_empty = 1'b0;
        rd_pulses = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.fifo_rd) rd_pulses++;
            @(posedge clk);
        end
        #1 bus.fifo_empty = 1'b1;
        @(negedge clk);
        chk("drop_pulses", rd_pulses, 300);
        chk("drop_saturate", drop_cnt, 255);

        // display_on held high with a pending command: no pop.
        @(posedge clk);
        #1 display_on = 1'b1;
        bus.fifo_hpos = 11'd1280; bus.fifo_vpos = 10'd5;
        bus.fifo_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_no_pop", bus.fifo_rd, 0);
        end
        @(posedge clk);
        #1 display_on = 1'b0;
        @(negedge clk);
        chk("hold_pop_after", bus.fifo_rd, 1);
        @(posedge clk);
        #1 bus.fifo_empty = 1'b1;
        @(negedge clk);
        chk("hold_drop_sat", drop_cnt, 255);

        // Preempt in WT for 5 cycles: read reissued, write lands afterwards.
        preload(12'd2, 6'h01);
        push_cmd(11'd80, 10'd0, 3'd6);
        @(posedge clk);
        #1 display_on = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wt_pre_no_we", bus.ram_we, 0);
            chk("wt_pre_busy", busy, 1);
            @(posedge clk);
        end
        #1 display_on = 1'b0;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.ram_we) begin
                lat = k;
                break;
            end
            @(posedge clk);
        end
        chk("wt_pre_latency", lat, 2);
        chk("wt_pre_addr", bus.ram_addr, 2);
        chk("wt_pre_wdata", bus.ram_wdata, 6'h31);
        exp_pix++;
        @(negedge clk);
        chk("wt_pre_pix_cnt", pix_cnt, exp_pix);

        // Preempt in WR: strobe suppressed, merged word retained.
        preload(12'd3, 6'h3F);
        push_cmd(11'd96, 10'd0, 3'd0);
        @(posedge clk);
        @(posedge clk);
        #1 display_on = 1'b1;
        @(negedge clk);
        chk("wr_pre_no_we", bus.ram_we, 0);
        chk("wr_pre_busy", busy, 1);
        chk("wr_pre_wdata", bus.ram_wdata, 6'h38);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wr_pre_no_we2", bus.ram_we, 0);
        chk("wr_pre_pix_hold", pix_cnt, exp_pix);
        @(posedge clk);
        #1 display_on = 1'b0;
        @(negedge clk);
        chk("wr_pre_we", bus.ram_we, 1);
        chk("wr_pre_addr", bus.ram_addr, 3);
        chk("wr_pre_wdata2", bus.ram_wdata, 6'h38);
        exp_pix++;
        @(negedge clk);
        chk("wr_pre_pix_cnt", pix_cnt, exp_pix);
        chk("wr_pre_idle", busy, 0);

        // Asynchronous reset while in WR aborts the write.
        preload(12'd4, 6'h15);
        push_cmd(11'd128, 10'd0, 3'd2);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rstwr_we_before", bus.ram_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstwr_we", bus.ram_we, 0);
        chk("rstwr_busy", busy, 0);
        chk("rstwr_pix_cnt", pix_cnt, 0);
        chk("rstwr_drop_cnt", drop_cnt, 0);
        exp_pix = 0;
        exp_drop = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rstwr_mem_kept", mem[4], 6'h15);

        // Recovery after reset.
        run_vec('{11'd16, 10'd16, 3'd4, 6'h00, 1'b0, 12'd40, 6'h20});

        chk("inv_no_we_in_display", bad_we, 0);
        chk("inv_pop_legal", bad_rd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
